// File: rtl/fighter_anim_compositor.sv
// ---------------------------------------------------------------------------
// fighter_anim_compositor
//
// Overlays a 96x64 fighter sprite on the OLED background stream and
// sequences the punch animation.
//
// Pixel path (two-stage, one pixel per clock, no stalls):
//   stage 1 : pixel_index -> sprite-local coordinates -> sprite_index,
//             in-range flag and background colour registered together
//   stage 2 : rom_colour (from the ROM addressed by sprite_index) or the
//             delayed background, chosen per transparency -> oled_data
//
// Animation FSM: IDLE -> WINDUP -> STRIKE -> RECOVER -> IDLE, each non-idle
// state held for HOLD_FRAMES OLED frames, advancing only on frame_begin.
//
// Parameters
//   HOLD_FRAMES  frames each non-idle state is held (1..15)
//   TRANSPARENT  sprite ROM colour that lets the background through
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   pixel_index   OLED scan index 0..6143 (x = idx mod 96, y = idx div 96)
//   frame_begin   one-cycle pulse at the start of every OLED frame
//   bg_colour     RGB565 background for the current pixel_index
//   off_x/off_y   signed sprite offset, latched on frame_begin
//   facing_left   mirror the sprite horizontally, latched on frame_begin
//   punch_req     one-cycle punch request
//   rom_colour    combinational colour from the selected sprite ROM
//   sprite_index  registered ROM address (native 96x64 coordinates)
//   frame_sel     ROM select: 0 idle, 1 windup/recover, 2 strike
//   oled_data     registered composited RGB565 pixel
//   hit_active    high while the STRIKE state is current
//   busy          high while animating or a punch is pending
// ---------------------------------------------------------------------------
module fighter_anim_compositor #(
  parameter int unsigned HOLD_FRAMES = 4,
  parameter logic [15:0] TRANSPARENT = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [12:0]       pixel_index,
  input  logic              frame_begin,
  input  logic [15:0]       bg_colour,
  input  logic signed [7:0] off_x,
  input  logic signed [6:0] off_y,
  input  logic              facing_left,
  input  logic              punch_req,
  input  logic [15:0]       rom_colour,
  output logic [12:0]       sprite_index,
  output logic [1:0]        frame_sel,
  output logic [15:0]       oled_data,
  output logic              hit_active,
  output logic              busy
);

  localparam int          DATA_W  = 16;
  localparam logic [3:0]  HOLD_M1 = 4'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WINDUP  = 2'd1,
    S_STRIKE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  // Transparent sprite pixels and off-sprite pixels both show the background.
  function automatic logic [DATA_W-1:0] f_composite(
    input logic              in_range,
    input logic [DATA_W-1:0] sprite,
    input logic [DATA_W-1:0] bg
  );
    return (in_range && (sprite != TRANSPARENT)) ? sprite : bg;
  endfunction

  // Frame-stable sprite placement.
  logic signed [7:0] r_off_x_l;
  logic signed [6:0] r_off_y_l;
  logic              r_facing_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_off_x_l  <= '0;
      r_off_y_l  <= '0;
      r_facing_l <= 1'b0;
    end else if (frame_begin) begin
      r_off_x_l  <= off_x;
      r_off_y_l  <= off_y;
      r_facing_l <= facing_left;
    end
  end

  // ---- stage 0 -> 1 : screen coordinates to sprite-local coordinates ----
  // 9-bit signed holds every x - off_x, its mirror and y - off_y without wrap.
  logic signed [8:0] w_x;
  logic signed [8:0] w_y;
  logic signed [8:0] w_rx_raw;
  logic signed [8:0] w_rx;
  logic signed [8:0] w_ry;
  logic              w_in_range;
  logic [12:0]       w_idx;

  assign w_x        = 9'(pixel_index % 13'd96);
  assign w_y        = 9'(pixel_index / 13'd96);
  assign w_rx_raw   = w_x - $signed({r_off_x_l[7], r_off_x_l});
  assign w_ry       = w_y - $signed({{2{r_off_y_l[6]}}, r_off_y_l});
  assign w_rx       = r_facing_l ? (9'sd95 - w_rx_raw) : w_rx_raw;
  assign w_in_range = (w_rx >= 9'sd0) && (w_rx <= 9'sd95) &&
                      (w_ry >= 9'sd0) && (w_ry <= 9'sd63);
  assign w_idx      = 13'(w_ry[5:0]) * 13'd96 + 13'(w_rx[6:0]);

  logic [12:0]       r_sprite_index_p1;
  logic              r_in_range_p1;
  logic [DATA_W-1:0] r_bg_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sprite_index_p1 <= '0;
      r_in_range_p1     <= 1'b0;
    end else begin
      r_sprite_index_p1 <= w_in_range ? w_idx : 13'd0;
      r_in_range_p1     <= w_in_range;
    end
  end

  always_ff @(posedge clk) begin
    r_bg_p1 <= bg_colour;
  end

  // ---- stage 1 -> 2 : composite ROM colour over background ----
  logic [DATA_W-1:0] r_oled_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oled_p2 <= '0;
    end else begin
      r_oled_p2 <= f_composite(r_in_range_p1, rom_colour, r_bg_p1);
    end
  end

  assign sprite_index = r_sprite_index_p1;
  assign oled_data    = r_oled_p2;

  // Animation sequencer. Outputs are registered from the next state so they
  // switch on the same edge as the state itself.
  state_t     r_state;
  state_t     w_state_n;
  logic       r_pending;
  logic       w_pending_n;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_n;
  logic [1:0] r_frame_sel;
  logic [1:0] w_frame_sel_n;
  logic       r_hit;
  logic       w_hit_n;
  logic       r_busy;
  logic       w_busy_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_cnt       <= '0;
      r_frame_sel <= 2'd0;
      r_hit       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pending   <= w_pending_n;
      r_cnt       <= w_cnt_n;
      r_frame_sel <= w_frame_sel_n;
      r_hit       <= w_hit_n;
      r_busy      <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_pending_n = r_pending;
    w_cnt_n     = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        // A request arriving on the frame_begin cycle starts immediately.
        if (frame_begin && (r_pending || punch_req)) begin
          w_state_n   = S_WINDUP;
          w_pending_n = 1'b0;
          w_cnt_n     = HOLD_M1;
        end else if (punch_req) begin
          w_pending_n = 1'b1;
        end
      end
      default: begin
        // Requests are dropped while animating; nothing is queued.
        if (frame_begin) begin
          if (r_cnt != 4'd0) begin
            w_cnt_n = r_cnt - 4'd1;
          end else begin
            w_cnt_n = HOLD_M1;
            unique case (r_state)
              S_WINDUP: w_state_n = S_STRIKE;
              S_STRIKE: w_state_n = S_RECOVER;
              default:  w_state_n = S_IDLE;
            endcase
          end
        end
      end
    endcase

    w_frame_sel_n = 2'd0;
    unique case (w_state_n)
      S_WINDUP:  w_frame_sel_n = 2'd1;
      S_STRIKE:  w_frame_sel_n = 2'd2;
      S_RECOVER: w_frame_sel_n = 2'd1;
      default:   w_frame_sel_n = 2'd0;
    endcase
    w_hit_n  = (w_state_n == S_STRIKE);
    w_busy_n = (w_state_n != S_IDLE) || w_pending_n;
  end

  assign frame_sel  = r_frame_sel;
  assign hit_active = r_hit;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fighter_anim_compositor.sv
// ---------------------------------------------------------------------------
// Testbench for fighter_anim_compositor.
// Stimulus issues one pixel per cycle and pushes the expected response into
// scoreboard queues; a monitor pops and compares one and two cycles later.
// The sprite ROM is emulated by a bench function driven from sprite_index.
// ---------------------------------------------------------------------------
module tb_fighter_anim_compositor;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] pixel_index = '0;
  logic        frame_begin = 1'b0;
  logic [15:0] bg_colour = '0;
  logic [7:0]  off_x = '0;
  logic [6:0]  off_y = '0;
  logic        facing_left = 1'b0;
  logic        punch_req = 1'b0;
  logic [15:0] rom_colour;
  logic [12:0] sprite_index;
  logic [1:0]  frame_sel;
  logic [15:0] oled_data;
  logic        hit_active;
  logic        busy;

  always #5 clk = ~clk;

  fighter_anim_compositor #(.HOLD_FRAMES(HOLD), .TRANSPARENT(16'h0000)) dut (
    .clk(clk), .reset(reset), .pixel_index(pixel_index),
    .frame_begin(frame_begin), .bg_colour(bg_colour), .off_x(off_x),
    .off_y(off_y), .facing_left(facing_left), .punch_req(punch_req),
    .rom_colour(rom_colour), .sprite_index(sprite_index),
    .frame_sel(frame_sel), .oled_data(oled_data),
    .hit_active(hit_active), .busy(busy)
  );

  // Emulated sprite ROM: every fifth address is transparent.
  function automatic logic [15:0] rom_fn(input logic [12:0] i);
    if (i % 13'd5 == 13'd0) return 16'h0000;
    return {3'b101, i};
  endfunction

  logic        g_force_en  = 1'b0;
  logic [15:0] g_force_val = '0;
  logic        force_en    = 1'b0;
  logic [15:0] force_val   = '0;
  assign rom_colour = force_en ? force_val : rom_fn(sprite_index);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    int idx;
    int sel;
    bit hit;
    bit bsy;
  } s1_t;
  s1_t q1[$];
  int  q2[$];

  // Reference model state
  logic [7:0] g_ox = '0;
  logic [6:0] g_oy = '0;
  logic       g_face = 1'b0;
  int m_ox = 0, m_oy = 0, m_frames = 0;
  bit m_face = 0, m_active = 0, m_pending = 0;
  logic drv_vld = 1'b0;

  task automatic step(input int pi, input logic [15:0] bg, input bit fb,
                      input bit pr, input bit rst, input bit vld);
    int x, y, rx, ry, idx;
    bit inr;
    logic [15:0] rc, eo;
    s1_t e;
    @(negedge clk);
    pixel_index = 13'(pi);
    bg_colour   = bg;
    frame_begin = fb;
    punch_req   = pr;
    reset       = rst;
    off_x       = g_ox;
    off_y       = g_oy;
    facing_left = g_face;
    force_en    = g_force_en;
    force_val   = g_force_val;
    drv_vld     = vld;
    if (rst) begin
      m_ox = 0; m_oy = 0; m_face = 0;
      m_active = 0; m_pending = 0; m_frames = 0;
    end else begin
      x  = pi % 96;
      y  = pi / 96;
      rx = x - m_ox;
      if (m_face) rx = 95 - rx;
      ry = y - m_oy;
      inr = (rx >= 0) && (rx <= 95) && (ry >= 0) && (ry <= 63);
      idx = inr ? (ry * 96 + rx) : 0;
      rc  = g_force_en ? g_force_val : rom_fn(13'(idx));
      eo  = (inr && rc != 16'h0000) ? rc : bg;
      // Punch timeline: frames counted since the punch started.
      if (!m_active) begin
        if (fb && (m_pending || pr)) begin
          m_active = 1; m_frames = 0; m_pending = 0;
        end else if (pr) begin
          m_pending = 1;
        end
      end else if (fb) begin
        m_frames++;
        if (m_frames == 3 * HOLD) m_active = 0;
      end
      if (fb) begin
        m_ox = int'($signed(g_ox));
        m_oy = int'($signed(g_oy));
        m_face = g_face;
      end
      if (vld) begin
        e.idx = idx;
        e.hit = m_active && (m_frames / HOLD == 1);
        e.sel = !m_active ? 0 : (e.hit ? 2 : 1);
        e.bsy = m_active || m_pending;
        q1.push_back(e);
        q2.push_back(int'(eo));
      end
    end
  endtask

  function automatic int rpix();
    return int'($urandom_range(0, 6143));
  endfunction

  task automatic rstep(input bit fb, input bit pr);
    step(rpix(), 16'($urandom), fb, pr, 1'b0, 1'b1);
  endtask

  task automatic set_force(input logic en, input logic [15:0] val);
    step(rpix(), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    g_force_en  = en;
    g_force_val = val;
  endtask

  task automatic do_reset();
    step(rpix(), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    step(rpix(), 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("rst_sprite_index", sprite_index, 0);
    chk("rst_oled_data", oled_data, 0);
    chk("rst_frame_sel", frame_sel, 0);
    chk("rst_hit_active", hit_active, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Monitor
  initial begin
    bit v1, v2;
    s1_t e;
    v1 = 0; v2 = 0;
    forever begin
      @(posedge clk);
      v2 = v1;
      v1 = drv_vld;
      #1;
      if (v1) begin
        if (q1.size() == 0) begin
          chk("mon_q1_underflow", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("mon_sprite_index", sprite_index, e.idx);
          chk("mon_frame_sel", frame_sel, e.sel);
          chk("mon_hit_active", hit_active, e.hit);
          chk("mon_busy", busy, e.bsy);
        end
      end
      if (v2) begin
        if (q2.size() == 0) chk("mon_q2_underflow", 1, 0);
        else chk("mon_oled_data", oled_data, q2.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete");
    summary();
    $finish;
  end

  // Stimulus
  initial begin
    int tbl[13];
    int fb_cnt;
    tbl = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 0};

    do_reset();

    // Plain placement, opaque sprite pixel
    g_ox = 0; g_oy = 0; g_face = 0;
    rstep(1, 0);
    set_force(1'b1, 16'hFFDF);
    step(1773, 16'h001F, 0, 0, 0, 1);
    @(posedge clk); #1 chk("opaque_idx", sprite_index, 1773);
    rstep(0, 0);
    @(posedge clk); #1 chk("opaque_oled", oled_data, 16'hFFDF);

    // Transparent sprite pixel shows background
    set_force(1'b1, 16'h0000);
    step(1773, 16'h001F, 0, 0, 0, 1);
    @(posedge clk); #1 chk("transp_idx", sprite_index, 1773);
    rstep(0, 0);
    @(posedge clk); #1 chk("transp_oled", oled_data, 16'h001F);
    set_force(1'b0, 16'h0000);

    // Sprite shifted right: left edge pixel is off-sprite
    g_ox = 8'd10;
    rstep(1, 0);
    step(5, 16'hABCD, 0, 0, 0, 1);
    @(posedge clk); #1 chk("offrange_idx", sprite_index, 0);
    rstep(0, 0);
    @(posedge clk); #1 chk("offrange_oled", oled_data, 16'hABCD);

    // Mirrored sprite: screen column 0 reads ROM column 95
    g_ox = 0; g_face = 1;
    rstep(1, 0);
    step(0, 16'h1234, 0, 0, 0, 1);
    @(posedge clk); #1 chk("mirror_idx", sprite_index, 95);
    g_face = 0;

    // Full punch, frame_begin every 100 cycles, extra request during STRIKE
    rstep(0, 1);
    @(posedge clk); #1;
    chk("pending_busy", busy, 1);
    chk("pending_sel", frame_sel, 0);
    for (int f = 0; f < 13; f++) begin
      for (int j = 0; j < 99; j++) rstep(0, (f == 5 && j == 50));
      rstep(1, 0);
      @(posedge clk); #1;
      chk("punch_sel", frame_sel, tbl[f]);
      chk("punch_hit", hit_active, tbl[f] == 2);
      chk("punch_busy", busy, tbl[f] != 0);
    end
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 19; j++) rstep(0, 0);
      rstep(1, 0);
      @(posedge clk); #1 chk("no_requeue_sel", frame_sel, 0);
    end

    // Request on the frame_begin cycle starts WINDUP at once; reset in STRIKE
    rstep(1, 1);
    @(posedge clk); #1 chk("same_cycle_sel", frame_sel, 1);
    for (int f = 0; f < HOLD; f++) begin
      for (int j = 0; j < 3; j++) rstep(0, 0);
      rstep(1, 0);
    end
    @(posedge clk); #1 chk("strike_hit", hit_active, 1);
    rstep(0, 1);
    do_reset();
    rstep(1, 0);
    @(posedge clk); #1 chk("post_reset_sel", frame_sel, 0);

    // Randomised run
    fb_cnt = 5;
    for (int c = 0; c < 3000; c++) begin
      bit fb;
      fb = 0;
      if (fb_cnt == 0) begin
        fb = 1;
        fb_cnt = int'($urandom_range(8, 40));
        if ($urandom_range(0, 3) == 0) begin
          g_ox = 8'($urandom);
          g_oy = 7'($urandom);
        end else begin
          g_ox = 8'(int'($urandom_range(0, 60)) - 30);
          g_oy = 7'(int'($urandom_range(0, 40)) - 20);
        end
        g_face = 1'($urandom);
      end else begin
        fb_cnt--;
      end
      if (c == 1500) do_reset();
      if (c == 700) set_force(1'b1, 16'($urandom));
      if (c == 760) set_force(1'b0, 16'h0000);
      rstep(fb, ($urandom_range(0, 29) == 0));
    end

    for (int j = 0; j < 3; j++) step(rpix(), 16'($urandom), 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("scoreboard_drained", q1.size() + q2.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/fighter_anim_compositor.md
FIGHTER_ANIM_COMPOSITOR -- requirements
Module: fighter_anim_compositor

Interface
REQ-001 Parameter HOLD_FRAMES, default 4: OLED frames each non-idle animation state is held (1..15).
REQ-002 Parameter TRANSPARENT, default 16'h0000: sprite ROM colour treated as see-through.
REQ-003 clk  in  1  system clock; one clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pixel_index  in  13  OLED scan index, 0..6143, x = index mod 96, y = index div 96.
REQ-006 frame_begin  in  1  one-cycle pulse from OLED driver at start of each frame.
REQ-007 bg_colour  in  16  RGB565 background for the current pixel_index.
REQ-008 off_x  in  8  signed horizontal sprite offset, pixels.
REQ-009 off_y  in  7  signed vertical sprite offset, pixels.
REQ-010 facing_left  in  1  1 = mirror sprite horizontally.
REQ-011 punch_req  in  1  one-cycle punch request pulse.
REQ-012 rom_colour  in  16  combinational colour returned by the selected sprite ROM for sprite_index.
REQ-013 sprite_index  out  13  registered index presented to sprite ROMs, native 96x64 ROM coordinates.
REQ-014 frame_sel  out  2  ROM select: 0 idle, 1 windup/recover, 2 strike; 3 unused.
REQ-015 oled_data  out  16  registered composited RGB565 pixel to OLED driver.
REQ-016 hit_active  out  1  high for every cycle the STRIKE state is current.
REQ-017 busy  out  1  high when state is not IDLE or a punch is pending.

Function
REQ-018 Pipeline stage 1 SHALL compute rx = x - off_x_l, ry = y - off_y_l (signed, 9-bit), then rx = 95 - rx if facing_l; in_range = 0<=rx<=95 and 0<=ry<=63.
REQ-019 sprite_index SHALL register ry*96 + rx when in_range, else 0; in_range and bg_colour SHALL be registered alongside it.
REQ-020 Stage 2 SHALL register oled_data = rom_colour if in_range_d and rom_colour != TRANSPARENT, else bg_colour_d.
REQ-021 Latency pixel_index -> oled_data SHALL be exactly 2 cycles, one result per cycle, no stalls.
REQ-022 off_x, off_y, facing_left SHALL be latched into off_x_l, off_y_l, facing_l only on frame_begin, so one frame never mixes positions.
REQ-023 FSM states: IDLE, WINDUP, STRIKE, RECOVER; frame_sel 0,1,2,1 respectively, registered from state.
REQ-024 punch_req while IDLE SHALL set pending; punch_req in any other state SHALL be ignored (no queuing).
REQ-025 On frame_begin in IDLE with pending (including punch_req on that same cycle) SHALL go to WINDUP, clear pending, load hold counter to HOLD_FRAMES-1.
REQ-026 On frame_begin in WINDUP/STRIKE/RECOVER: counter nonzero -> decrement; zero -> advance WINDUP->STRIKE->RECOVER->IDLE, reloading counter to HOLD_FRAMES-1.
REQ-027 State and frame_sel SHALL change only on the frame_begin cycle; a punch therefore lasts exactly 3*HOLD_FRAMES frames.
REQ-028 frame_begin and pixel_index handling are independent; the pixel pipeline runs continuously in all states.

Reset
REQ-029 On reset: state IDLE, pending 0, counter 0, frame_sel 0, hit_active 0, busy 0, sprite_index 0, oled_data 16'h0000, latched offsets 0, facing_l 0, pipeline in_range 0.
REQ-030 Reset asserted mid-punch SHALL abort to IDLE on the next edge, dropping any pending request.

Verification
REQ-031 Offsets 0, facing 0, pixel_index 1773, rom_colour 16'hFFDF, bg 16'h001F -> sprite_index 1773 after 1 cycle, oled_data 16'hFFDF after 2.
REQ-032 Same pixel, rom_colour 16'h0000 -> oled_data 16'h001F (background shows through).
REQ-033 off_x 10 latched, pixel_index 5 (x=5) -> in_range 0, sprite_index 0, oled_data = bg_colour; facing 1, off 0, pixel_index 0 -> sprite_index 95.
REQ-034 HOLD_FRAMES 4, punch_req then frame_begin every 100 cycles -> frame_sel 1 for 4 frames, 2 for 4 frames (hit_active high), 1 for 4, then 0; busy high from request to final return.
REQ-035 punch_req during STRIKE -> no second punch after RECOVER; punch_req and frame_begin same IDLE cycle -> WINDUP that cycle.
REQ-036 reset pulsed during STRIKE -> next cycle frame_sel 0, hit_active 0, busy 0, oled_data 16'h0000.
